// File: rtl/parity_frame_pkg.sv
// Shared state encodings and counter sizing for the parity frame controller.
`ifndef PARITY_FRAME_PKG_SV
`define PARITY_FRAME_PKG_SV
`define PF_CNT_W(w) ($clog2(w))

package parity_frame_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Bit counter width; WIDTH is at least 2, so this is never zero.
  function automatic int pf_cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

`endif

// File: rtl/odd_parity_cell.sv
// Serial odd-parity accumulator: one toggle flop, synchronous clear wins over enable.
// Updates on the edge after x_in is presented; no backpressure.
module odd_parity_cell (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  input  logic en,
  input  logic x_in,
  output logic odd_out
);

  logic r_odd;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_odd <= 1'b0;
    end else if (clr) begin
      r_odd <= 1'b0;
    end else if (en && x_in) begin
      r_odd <= ~r_odd;
    end
  end

  assign odd_out = r_odd;

endmodule

// File: rtl/parity_frame_ctrl.sv
// Frame sequencer: loads a WIDTH-bit word, serializes it into the parity cell, returns odd/even.
// Result is valid WIDTH clocks after accept; in_ready follows out_ready while a result waits.
// Optional PARITY_FRAME_ERR_EN adds an expected-parity check and a saturating error counter.
module parity_frame_ctrl
  import parity_frame_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter logic        MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  output logic             ser_bit,
  output logic             ser_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_odd
`ifdef PARITY_FRAME_ERR_EN
  ,
  input  logic             exp_par,
  output logic             par_err,
  output logic [7:0]       err_cnt
`endif
);

  localparam int CNT_W = pf_cnt_w(int'(WIDTH));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_odd_hold;

  logic w_idle;
  logic w_shift;
  logic w_done;
  logic w_accept;
  logic w_retire;
  logic w_last;
  logic w_head;
  logic w_cell_odd;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_shift = (r_state == ST_SHIFT);
  assign w_done  = (r_state == ST_DONE);

  // Held low through reset so a producer never sees a handshake it cannot complete.
  assign in_ready = rstb & (w_idle | (w_done & out_ready));

  assign w_accept = in_valid & in_ready & ~abort;
  assign w_retire = w_done & out_ready & ~abort;
  assign w_last   = w_shift & (r_cnt == LAST_CNT);
  assign w_head   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) w_state_nxt = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_last) w_state_nxt = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) w_state_nxt = in_valid ? ST_SHIFT : ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (abort) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_shift <= in_data;
        r_cnt   <= '0;
      end else if (w_shift) begin
        r_shift <= MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
        if (!w_last) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Accepting on the retire edge clears the cell, so the old frame cannot leak forward.
  odd_parity_cell u_cell (
    .clk     (clk),
    .rstb    (rstb),
    .clr     (w_accept | abort),
    .en      (w_shift),
    .x_in    (w_head),
    .odd_out (w_cell_odd)
  );

  // The cell is reused by the next frame, so the last delivered result is kept here.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_odd_hold <= 1'b0;
    end else if (w_retire) begin
      r_odd_hold <= w_cell_odd;
    end
  end

  assign ser_en    = w_shift;
  assign ser_bit   = w_shift & w_head;
  assign out_valid = w_done;
  assign out_odd   = w_done ? w_cell_odd : r_odd_hold;

`ifdef PARITY_FRAME_ERR_EN
  logic       r_exp_par;
  logic [7:0] r_err_cnt;

  assign par_err = w_done & (w_cell_odd != r_exp_par);
  assign err_cnt = r_err_cnt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_exp_par <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      if (w_accept) r_exp_par <= exp_par;
      if (w_retire && par_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end
`endif

endmodule
